crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Frame-based streaming CRC generator/checker. Absorbs DATA_W bits per accepted beat, MSB-first.
//  Parametrised in CRC width, polynomial, beat width, init and output XOR.
//  Generate mode: presents the CRC at end of frame. Check mode: flags whether the frame,
//  with its CRC appended, left the expected residue.
//  Sits between a nibble/byte source and the framing logic.
// PARAMETERS
//  CRC_W    12      CRC register width (2..32)
//  POLY     12'h80F generator polynomial without the x^CRC_W term (x^12+x^11+x^3+x^2+x+1)
//  DATA_W   4       bits absorbed per beat (1..CRC_W)
//  INIT     0       register value loaded at start of frame
//  XOR_OUT  0       XOR applied to crc_out (generate mode only)
//  RESIDUE  0       register value that signals a good frame in check mode
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  in_valid   in   1       beat present on in_data
//  in_ready   out  1       engine accepts a beat this cycle
//  in_data    in   DATA_W  beat payload; bit DATA_W-1 is processed first
//  in_sof     in   1       beat is the first of a frame
//  in_eof     in   1       beat is the last of a frame
//  chk_mode   in   1       sampled on the SOF beat: 0 = generate, 1 = check
//  crc_out    out  CRC_W   final CRC (generate) or raw register (check)
//  crc_ok     out  1       check mode: register == RESIDUE; always 0 in generate mode
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       consumer takes the result
// BEHAVIOUR
//  - Reset values: in_ready=1, out_valid=0, crc_out=0, crc_ok=0. State IDLE, register=INIT.
//  - Accept = in_valid & in_ready. in_ready = (state != RESULT).
//  - States: IDLE -> ACCUM on an accepted SOF beat without EOF.
//    IDLE -> RESULT on an accepted SOF+EOF beat (single-beat frame).
//    ACCUM -> RESULT on an accepted EOF beat.
//    RESULT -> IDLE when out_valid & out_ready.
//  - Step function per bit: fb = r[CRC_W-1]^d; r = r<<1 (truncated to CRC_W); if fb, r ^= POLY.
//    DATA_W steps are applied combinationally per beat, i.e. one beat per clock.
//  - The SOF beat is stepped from INIT, not from the current register.
//    chk_mode is latched on the SOF beat and held for the whole frame.
//  - Latency: out_valid rises the cycle after the EOF beat is accepted.
//    crc_out and crc_ok are registered and stable while out_valid=1.
//  - Generate mode: crc_out = r ^ XOR_OUT. Check mode: crc_out = r, crc_ok = (r == RESIDUE).
//  - Accepted beat without SOF while IDLE: dropped, no state change.
//  - Accepted SOF while ACCUM: the current frame is abandoned and a new frame restarts
//    from INIT; no result is produced for the abandoned frame.
//  - RESULT state: in_ready=0. Beats are not consumed; the upstream holds them.
//  - out_ready asserted when out_valid=0: ignored.
//  - rst asserted mid-frame or mid-RESULT: immediate return to the reset values.
//    A pending result is lost.
// STRUCTURE
//  - crc_pkg: the CRC12_POLY=12'h80F and CRC16_CCITT_POLY=16'h1021 constants;
//    a state enum {IDLE, ACCUM, RESULT}.
//  - Sub-module crc_step: combinational DATA_W-bit step (r_in, d, POLY) -> r_out.
//    Reusable by other CRC blocks.
//  - Top: FSM, register, mode latch, output registers.
// TESTING (defaults unless stated)
//  1. SOF+EOF beat 4'h1, chk_mode=0 -> next cycle out_valid=1, crc_out=12'h80F, crc_ok=0.
//  2. SOF+EOF beat 4'hA -> crc_out=12'h044.
//     Frame {4'h1, 4'h0} -> crc_out=12'h8A5, out_valid one cycle after the second beat.
//  3. Check mode, frame {1,8,0,F} (data 4'h1 plus CRC 12'h80F) -> crc_ok=1, crc_out=0.
//     Frame {1,8,0,E} -> crc_ok=0.
//  4. Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, result stable.
//     On out_ready=1, the next beat is accepted the following cycle.
//  5. Frame {1 (SOF), 0, 1 (SOF), A (EOF)}: the first frame is abandoned.
//     Result equals the two-beat frame {1, A}. Non-SOF beats sent while IDLE produce no result.
//  6. rst pulse during ACCUM and during RESULT -> outputs return to reset values asynchronously.
//     The next frame {1} yields 12'h80F.
//     Re-run 1-3 with CRC_W=16, POLY=16'h1021, DATA_W=8 against a software model.

Source files
------------

// File: rtl/crc_pkg.sv
// Package shared by the CRC streaming blocks.
// Contents:
//   CRC12_POLY        x^12+x^11+x^3+x^2+x+1 without the x^12 term
//   CRC16_CCITT_POLY  x^16+x^12+x^5+1 without the x^16 term
//   state_t           frame FSM states
package crc_pkg;

  localparam logic [11:0] CRC12_POLY       = 12'h80F;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC step: folds DATA_W data bits into a CRC_W register,
// MSB of d_i first. Per bit: fb = r[msb] ^ d; r = r << 1; if fb, r ^= POLY.
// Ports:
//   r_i  register value before the beat
//   d_i  beat payload, bit DATA_W-1 processed first
//   r_o  register value after all DATA_W bits
module crc_step #(
  parameter int               CRC_W  = 12,
  parameter int               DATA_W = 4,
  parameter logic [CRC_W-1:0] POLY   = 12'h80F
) (
  input  logic [CRC_W-1:0]  r_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [CRC_W-1:0]  r_o
);

  logic [CRC_W-1:0] acc;

  always_comb begin
    acc = r_i;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (acc[CRC_W-1] ^ d_i[i]) begin
        acc = {acc[CRC_W-2:0], 1'b0} ^ POLY;
      end else begin
        acc = {acc[CRC_W-2:0], 1'b0};
      end
    end
    r_o = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-based streaming CRC generator/checker, one DATA_W beat per clock.
// Handshake: a beat transfers on a rising edge where in_valid_i & in_ready_o;
// a result transfers on a rising edge where out_valid_o & out_ready_i. Valid
// sides hold their payload stable until the transfer happens.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid_i     beat present on in_data_i
//   in_ready_o     engine accepts a beat (low only while a result is pending)
//   in_data_i      beat payload, MSB processed first
//   in_sof_i       first beat of a frame
//   in_eof_i       last beat of a frame
//   chk_mode_i     sampled on SOF: 0 = generate, 1 = check
//   crc_out_o      final CRC ^ XOR_OUT (generate) or raw register (check)
//   crc_ok_o       check mode: register == RESIDUE; 0 in generate mode
//   out_valid_o    result valid, held until out_ready_i
//   out_ready_i    consumer takes the result
//   dbg_state_o    current FSM state
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 12,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC12_POLY),
  parameter int               DATA_W  = 4,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sof_i,
  input  logic              in_eof_i,
  input  logic              chk_mode_i,
  output logic [CRC_W-1:0]  crc_out_o,
  output logic              crc_ok_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output state_t            dbg_state_o
);

  state_t           state_q;
  logic [CRC_W-1:0] r_q;
  logic             mode_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             crc_ok_q;
  logic             out_valid_q;

  logic             accept;
  logic [CRC_W-1:0] r_seed;
  logic [CRC_W-1:0] r_d;
  logic             frame_mode;
  logic [CRC_W-1:0] res_crc_d;
  logic             res_ok_d;

  assign in_ready_o  = (state_q != RESULT);
  assign accept      = in_valid_i & in_ready_o;
  assign crc_out_o   = crc_out_q;
  assign crc_ok_o    = crc_ok_q;
  assign out_valid_o = out_valid_q;
  assign dbg_state_o = state_q;

  // An SOF beat always starts from INIT and uses the mode presented with it,
  // which also covers restarting an abandoned frame from ACCUM.
  always_comb begin
    r_seed     = in_sof_i ? INIT : r_q;
    frame_mode = in_sof_i ? chk_mode_i : mode_q;
    res_crc_d  = frame_mode ? r_d : (r_d ^ XOR_OUT);
    res_ok_d   = frame_mode && (r_d == RESIDUE);
  end

  crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .r_i (r_seed),
    .d_i (in_data_i),
    .r_o (r_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= INIT;
      mode_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Non-SOF beats while idle are consumed and dropped.
          if (accept && in_sof_i) begin
            r_q    <= r_d;
            mode_q <= chk_mode_i;
            if (in_eof_i) begin
              crc_out_q   <= res_crc_d;
              crc_ok_q    <= res_ok_d;
              out_valid_q <= 1'b1;
              state_q     <= RESULT;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            r_q <= r_d;
            if (in_sof_i) begin
              mode_q <= chk_mode_i;
            end
            if (in_eof_i) begin
              crc_out_q   <= res_crc_d;
              crc_ok_q    <= res_ok_d;
              out_valid_q <= 1'b1;
              state_q     <= RESULT;
            end
          end
        end
        RESULT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk;
  logic rst;

  // default instance: CRC-12, 4-bit beats
  logic        in_valid, in_sof, in_eof, chk_mode, out_ready;
  logic [3:0]  in_data;
  logic        in_ready, crc_ok, out_valid;
  logic [11:0] crc_out;
  state_t      dbg_state;

  // second instance: CRC-16/CCITT, 8-bit beats
  logic        s_valid, s_sof, s_eof, s_mode, s_out_ready;
  logic [7:0]  s_data;
  logic        s_ready, s_ok, s_out_valid;
  logic [15:0] s_crc;
  state_t      s_state;

  int n_assert;
  int n_fail;

  crc_stream_engine u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sof_i    (in_sof),
    .in_eof_i    (in_eof),
    .chk_mode_i  (chk_mode),
    .crc_out_o   (crc_out),
    .crc_ok_o    (crc_ok),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .dbg_state_o (dbg_state)
  );

  crc_stream_engine #(
    .CRC_W  (16),
    .POLY   (CRC16_CCITT_POLY),
    .DATA_W (8)
  ) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .in_data_i   (s_data),
    .in_sof_i    (s_sof),
    .in_eof_i    (s_eof),
    .chk_mode_i  (s_mode),
    .crc_out_o   (s_crc),
    .crc_ok_o    (s_ok),
    .out_valid_o (s_out_valid),
    .out_ready_i (s_out_ready),
    .dbg_state_o (s_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // bit-serial CRC-16/CCITT reference, MSB first
  function automatic logic [15:0] m16(input logic [15:0] r, input logic [7:0] b);
    logic [15:0] v;
    logic        fb;
    v = r;
    for (int i = 7; i >= 0; i--) begin
      fb = v[15] ^ b[i];
      v  = {v[14:0], 1'b0};
      if (fb) v = v ^ 16'h1021;
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  // One beat presented for exactly one rising edge.
  task automatic beat(input logic [3:0] d, input logic sof, input logic eof, input logic mode);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof; chk_mode = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic beat16(input logic [7:0] d, input logic sof, input logic eof, input logic mode);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof; s_mode = mode;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic take16();
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]  msg [9];
    logic [7:0]  rb  [4];
    logic [15:0] exp16;

    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    in_valid = 0; in_sof = 0; in_eof = 0; chk_mode = 0; out_ready = 0; in_data = '0;
    s_valid = 0; s_sof = 0; s_eof = 0; s_mode = 0; s_out_ready = 0; s_data = '0;

    @(negedge clk);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_crc_out",   crc_out,   0);
    chk("rst_crc_ok",    crc_ok,    0);
    chk("rst_state",     dbg_state, IDLE);
    rst = 1'b0;

    // 1: single-beat frame 4'h1
    beat(4'h1, 1, 1, 0);
    @(negedge clk);
    chk("t1_valid",    out_valid, 1);
    chk("t1_crc",      crc_out,   12'h80F);
    chk("t1_ok",       crc_ok,    0);
    chk("t1_in_ready", in_ready,  0);
    take();
    @(negedge clk);
    chk("t1_released", out_valid, 0);

    // 2: single beat 4'hA, then two-beat frame {1,0}
    beat(4'hA, 1, 1, 0);
    @(negedge clk);
    chk("t2a_crc", crc_out, 12'h044);
    take();
    beat(4'h1, 1, 0, 0);
    @(negedge clk);
    chk("t2b_not_yet", out_valid, 0);
    beat(4'h0, 0, 1, 0);
    @(negedge clk);
    chk("t2b_valid", out_valid, 1);
    chk("t2b_crc",   crc_out,   12'h8A5);
    take();

    // 3: check mode, good and corrupted frames
    beat(4'h1, 1, 0, 1);
    beat(4'h8, 0, 0, 0);
    beat(4'h0, 0, 0, 0);
    beat(4'hF, 0, 1, 0);
    @(negedge clk);
    chk("t3a_ok",  crc_ok,  1);
    chk("t3a_crc", crc_out, 12'h000);
    take();
    beat(4'h1, 1, 0, 1);
    beat(4'h8, 0, 0, 0);
    beat(4'h0, 0, 0, 0);
    beat(4'hE, 0, 1, 0);
    @(negedge clk);
    chk("t3b_ok",  crc_ok,  0);
    chk("t3b_crc", crc_out, 12'h80F);

    // 4: back-pressure with a beat waiting upstream
    in_valid = 1'b1; in_data = 4'hA; in_sof = 1'b1; in_eof = 1'b1; chk_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_hold_crc", crc_out,  12'h80F);
      chk("t4_hold_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_again", in_ready,  1);
    chk("t4_drained",     out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    @(negedge clk);
    chk("t4_next_vld", out_valid, 1);
    chk("t4_next_crc", crc_out,   12'h044);
    take();

    // 5: abandoned frame, then stray beats while idle
    beat(4'h1, 1, 0, 0);
    beat(4'h0, 0, 0, 0);
    beat(4'h1, 1, 0, 0);
    beat(4'hA, 0, 1, 0);
    @(negedge clk);
    chk("t5_crc", crc_out, 12'h8E1);
    take();
    beat(4'h5, 0, 0, 0);
    beat(4'h3, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_stray_vld",   out_valid, 0);
    chk("t5_stray_state", dbg_state, IDLE);

    // 6: asynchronous reset in ACCUM and in RESULT
    beat(4'h1, 1, 0, 0);
    @(negedge clk);
    chk("t6_accum", dbg_state, ACCUM);
    rst = 1'b1;
    #1;
    chk("t6a_state", dbg_state, IDLE);
    chk("t6a_ready", in_ready,  1);
    #2 rst = 1'b0;
    beat(4'h1, 1, 1, 0);
    @(negedge clk);
    chk("t6_pending", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6b_vld",   out_valid, 0);
    chk("t6b_crc",   crc_out,   0);
    chk("t6b_ready", in_ready,  1);
    #2 rst = 1'b0;
    beat(4'h1, 1, 1, 0);
    @(negedge clk);
    chk("t6_after_crc", crc_out, 12'h80F);
    take();

    // CRC-16/CCITT, 8-bit beats
    beat16(8'h01, 1, 1, 0);
    @(negedge clk);
    chk("c16_one_vld", s_out_valid, 1);
    chk("c16_one_crc", s_crc,       16'h1021);
    take16();
    // "123456789" -> 0x31C3 (CRC-16/XMODEM check value)
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 9; i++) beat16(msg[i], i == 0, i == 8, 0);
    @(negedge clk);
    chk("c16_check_crc", s_crc, 16'h31C3);
    chk("c16_check_ok",  s_ok,  0);
    take16();
    for (int i = 0; i < 9; i++) beat16(msg[i], i == 0, 0, i == 0);
    beat16(8'h31, 0, 0, 0);
    beat16(8'hC3, 0, 1, 0);
    @(negedge clk);
    chk("c16_res_ok",  s_ok,  1);
    chk("c16_res_crc", s_crc, 16'h0000);
    take16();
    // flipping the last bit leaves exactly POLY in the register
    for (int i = 0; i < 9; i++) beat16(msg[i], i == 0, 0, i == 0);
    beat16(8'h31, 0, 0, 0);
    beat16(8'hC2, 0, 1, 0);
    @(negedge clk);
    chk("c16_bad_ok",  s_ok,  0);
    chk("c16_bad_crc", s_crc, 16'h1021);
    take16();
    // random 4-byte frames against the reference model
    for (int k = 0; k < 3; k++) begin
      exp16 = 16'h0000;
      for (int i = 0; i < 4; i++) begin
        rb[i] = 8'($urandom_range(0, 255));
        exp16 = m16(exp16, rb[i]);
      end
      for (int i = 0; i < 4; i++) beat16(rb[i], i == 0, i == 3, 0);
      @(negedge clk);
      chk("c16_rand_crc", s_crc, exp16);
      take16();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
